// File: rtl/tts_status_fsm_if.sv
// Bundle of the TTS status signals exchanged between the status FSM and its consumer.
//   master : drives ttc_locked, fill_level, sync_err, fatal_err, clear;
//            observes ttc_ready, tts_state, state_change
//   slave  : the status FSM itself (mirror image of master)
interface tts_status_fsm_if #(
  parameter int unsigned FILL_W = 12
) ();

  logic              ttc_locked;
  logic [FILL_W-1:0] fill_level;
  logic              sync_err;
  logic              fatal_err;
  logic              clear;
  logic              ttc_ready;
  logic [3:0]        tts_state;
  logic              state_change;

  modport master (
    output ttc_locked,
    output fill_level,
    output sync_err,
    output fatal_err,
    output clear,
    input  ttc_ready,
    input  tts_state,
    input  state_change
  );

  modport slave (
    input  ttc_locked,
    input  fill_level,
    input  sync_err,
    input  fatal_err,
    input  clear,
    output ttc_ready,
    output tts_state,
    output state_change
  );

endinterface

// File: rtl/tts_status_fsm.sv
// Produces the qualified TTC lock and the 4-bit CMS TTS code for the front-panel LED logic.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset; forces every output to 0 (DISCONNECTED)
//   tts_io : slave side of tts_status_fsm_if
//            in  ttc_locked, fill_level, sync_err, fatal_err, clear
//            out ttc_ready, tts_state, state_change (all registered)
module tts_status_fsm #(
  parameter int unsigned FILL_W      = 12,
  parameter int unsigned WARN_HI     = 2048,
  parameter int unsigned WARN_LO     = 1536,
  parameter int unsigned BUSY_HI     = 3584,
  parameter int unsigned BUSY_LO     = 3072,
  parameter int unsigned LOCK_CYCLES = 1024
) (
  input logic               clk,
  input logic               rst_n,
  tts_status_fsm_if.slave   tts_io
);

  localparam int unsigned CntW = $clog2(LOCK_CYCLES + 1);

  localparam logic [CntW-1:0]   LockMax = CntW'(LOCK_CYCLES);
  localparam logic [FILL_W-1:0] WarnHi  = FILL_W'(WARN_HI);
  localparam logic [FILL_W-1:0] WarnLo  = FILL_W'(WARN_LO);
  localparam logic [FILL_W-1:0] BusyHi  = FILL_W'(BUSY_HI);
  localparam logic [FILL_W-1:0] BusyLo  = FILL_W'(BUSY_LO);

  localparam logic [3:0] TtsDisconnected = 4'b0000;
  localparam logic [3:0] TtsError        = 4'b1100;
  localparam logic [3:0] TtsOutOfSync    = 4'b0010;
  localparam logic [3:0] TtsBusy         = 4'b0100;
  localparam logic [3:0] TtsOverflowWarn = 4'b0001;
  localparam logic [3:0] TtsReady        = 4'b1000;

  typedef enum logic [1:0] {OccReady, OccWarn, OccBusy} occ_e;

  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
  logic            ready_q, ready_d;
  logic            sync_q, sync_d;
  logic            fatal_q, fatal_d;
  occ_e            occ_q, occ_d;
  logic [3:0]      tts_q, tts_d;
  logic            chg_q, chg_d;

  always_comb begin
    // Lock qualifier: any unlocked sample restarts the count and drops ready at once.
    lock_cnt_d = '0;
    ready_d    = 1'b0;
    if (tts_io.ttc_locked) begin
      lock_cnt_d = (lock_cnt_q == LockMax) ? LockMax : lock_cnt_q + CntW'(1);
      ready_d    = (lock_cnt_d == LockMax);
    end

    // Set has priority over clear so a fault coinciding with a resync is not lost.
    sync_d  = tts_io.sync_err  | (sync_q  & ~tts_io.clear);
    fatal_d = tts_io.fatal_err | (fatal_q & ~tts_io.clear);

    // Occupancy hysteresis; keeps tracking even while a higher-priority code is shown.
    occ_d = occ_q;
    unique case (occ_q)
      OccReady: begin
        if (tts_io.fill_level >= BusyHi)      occ_d = OccBusy;
        else if (tts_io.fill_level >= WarnHi) occ_d = OccWarn;
      end
      OccWarn: begin
        if (tts_io.fill_level >= BusyHi)      occ_d = OccBusy;
        else if (tts_io.fill_level < WarnLo)  occ_d = OccReady;
      end
      OccBusy: begin
        if (tts_io.fill_level < BusyLo) begin
          occ_d = (tts_io.fill_level < WarnLo) ? OccReady : OccWarn;
        end
      end
      default: occ_d = OccReady;
    endcase

    // Code is chosen from next-state values so inputs show up on the same edge.
    if (!ready_d)              tts_d = TtsDisconnected;
    else if (fatal_d)          tts_d = TtsError;
    else if (sync_d)           tts_d = TtsOutOfSync;
    else if (occ_d == OccBusy) tts_d = TtsBusy;
    else if (occ_d == OccWarn) tts_d = TtsOverflowWarn;
    else                       tts_d = TtsReady;

    chg_d = (tts_d != tts_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_q <= '0;
      ready_q    <= 1'b0;
      sync_q     <= 1'b0;
      fatal_q    <= 1'b0;
      occ_q      <= OccReady;
      tts_q      <= TtsDisconnected;
      chg_q      <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      ready_q    <= ready_d;
      sync_q     <= sync_d;
      fatal_q    <= fatal_d;
      occ_q      <= occ_d;
      tts_q      <= tts_d;
      chg_q      <= chg_d;
    end
  end

  assign tts_io.ttc_ready    = ready_q;
  assign tts_io.tts_state    = tts_q;
  assign tts_io.state_change = chg_q;

endmodule
